// File: rtl/regmap_defs.sv
// Shared definitions for the register-map access controller.
//   - FSM state encoding for regmap_arbiter
//   - Address-field layout (RW_BIT) and register-map depth (REGMAP_MAXADDR)
//   - Default WAIT-state timeout
//   - idx_width(): index width for a requester count (min 1 bit)
package regmap_defs;

  localparam int RW_BIT          = 7;   // addr bit 7: 1 = write, 0 = read
  localparam int REGMAP_MAXADDR  = 8;   // register map implements indices 0..7
  localparam int DEFAULT_TIMEOUT = 15;  // WAIT cycles before an access is aborted

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_TURN,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection with its own last-grant pointer.
//   clk, rst_n  : clock / asynchronous active-low reset
//   req         : per-requester request vector
//   update      : load update_idx into the last-grant pointer
//   update_idx  : index that was just served
//   gnt_valid   : at least one request is pending
//   gnt_idx     : winner, searching upward from last_grant+1 with wrap
// The pointer resets to N-1 so requester 0 has first priority.
module rr_arbiter
  import regmap_defs::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update,
  input  logic [IW-1:0] update_idx,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] last_grant;

  // Walk candidates from farthest (last_grant+N) to nearest (last_grant+1);
  // the nearest pending requester is written last and therefore wins.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % N;
      if (req[cand[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N - 1);
    end else if (update) begin
      last_grant <= update_idx;
    end
  end

endmodule

// File: rtl/regmap_arbiter.sv
// Shares the register map's single address/data bus among NUM_REQ requesters.
//   clk, rst_n            : clock / asynchronous active-low reset
//   req_valid/addr/wdata  : per-requester access (addr bit 7 = write)
//   req_done, req_err     : completion pulse to the served requester, 1 = timeout
//   rsp_rdata             : read data valid with req_done (0x00 on write/error)
//   regmap_in             : one-cycle access strobe to the register map
//   regmap_out            : register map may drive data_bus (reads, WAIT only)
//   regmap_data_available : register map completion pulse, honoured in WAIT only
//   addr_bus, data_bus    : register map address / shared bidirectional data
// Access sequence: IDLE -> ISSUE -> TURN -> WAIT -> DONE -> IDLE. TURN keeps
// the arbiter's drive (ISSUE) and the register map's drive (WAIT) apart.
// All outputs are registered from the next state so they line up with it.
module regmap_arbiter
  import regmap_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 req_err,
  output logic [7:0]           rsp_rdata,
  output logic                 regmap_in,
  output logic                 regmap_out,
  input  logic                 regmap_data_available,
  output logic [7:0]           addr_bus,
  inout  wire  [7:0]           data_bus
);

  localparam int            IW       = idx_width(NUM_REQ);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q;
  logic [7:0]    wdata_q;
  logic          drive_q;
  logic [CW-1:0] cnt_q;
  logic          arb_valid;
  logic [IW-1:0] arb_idx;
  logic          is_read;
  logic          wait_exit;

  // addr_bus holds the latched address for the whole access.
  assign is_read   = !addr_bus[RW_BIT];
  assign wait_exit = (state_q == ST_WAIT) && (state_d == ST_DONE);

  assign data_bus = drive_q ? wdata_q : 'z;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .update     (state_q == ST_DONE),
    .update_idx (grant_q),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // WAIT lasts at most TIMEOUT cycles (counter values 0..TIMEOUT-1); an
  // acknowledge in the final cycle still completes without error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_TURN;
      ST_TURN:  state_d = ST_WAIT;
      ST_WAIT:  if (regmap_data_available || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      cnt_q      <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      rsp_rdata  <= 8'h00;
      regmap_in  <= 1'b0;
      regmap_out <= 1'b0;
      addr_bus   <= 8'h00;
    end else begin
      regmap_in  <= (state_d == ST_ISSUE);
      drive_q    <= (state_d == ST_ISSUE);
      regmap_out <= (state_d == ST_WAIT) && is_read;
      req_done   <= '0;

      if (state_q == ST_IDLE && arb_valid) begin
        grant_q  <= arb_idx;
        addr_bus <= req_addr[8*arb_idx +: 8];
        wdata_q  <= req_wdata[8*arb_idx +: 8];
      end

      if (state_q == ST_WAIT)      cnt_q <= cnt_q + 1'b1;
      else if (state_q == ST_DONE) cnt_q <= '0;

      if (wait_exit) begin
        req_done[grant_q] <= 1'b1;
        if (regmap_data_available) begin
          req_err   <= 1'b0;
          rsp_rdata <= is_read ? data_bus : 8'h00;
        end else begin
          req_err   <= 1'b1;
          rsp_rdata <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_regmap_arbiter.sv
// Directed bench for regmap_arbiter with a behavioural register-map model.
module tb_regmap_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_done;
  logic                 req_err;
  logic [7:0]           rsp_rdata;
  logic                 regmap_in;
  logic                 regmap_out;
  logic                 regmap_data_available;
  logic [7:0]           addr_bus;
  wire  [7:0]           data_bus;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regmap_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_done              (req_done),
    .req_err               (req_err),
    .rsp_rdata             (rsp_rdata),
    .regmap_in             (regmap_in),
    .regmap_out            (regmap_out),
    .regmap_data_available (regmap_data_available),
    .addr_bus              (addr_bus),
    .data_bus              (data_bus)
  );

  // Released bus floats to 0xFF so "nobody drives" is observable.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  // ---------------- register map model ----------------
  logic [7:0] mem [8];
  logic [7:0] m_rdata = 8'h00;
  logic [1:0] stage   = 2'd0;
  logic       ack_en  = 1'b1;
  int         conflicts = 0;

  assign data_bus = regmap_out ? m_rdata : 8'hzz;

  always @(negedge clk) begin
    regmap_data_available = 1'b0;
    case (stage)
      2'd0: if (regmap_in) begin
        if (addr_bus[7] && addr_bus[6:0] < 7'd8) mem[addr_bus[2:0]] = data_bus;
        m_rdata = (!addr_bus[7] && addr_bus[6:0] < 7'd8) ? mem[addr_bus[2:0]] : 8'h00;
        stage = 2'd1;
      end
      2'd1: stage = 2'd2;
      default: begin
        if (ack_en) regmap_data_available = 1'b1;
        stage = 2'd0;
      end
    endcase
  end

  // Strobe and read drive overlapping, or a read bus that is not the model's value.
  always @(negedge clk) begin
    if (regmap_out && (regmap_in || data_bus !== m_rdata)) conflicts++;
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_access(input int idx, input logic [7:0] addr, input logic [7:0] wdata,
                           input int drop_at, output int lat, output int strobes,
                           output logic [7:0] rdata, output logic err);
    lat = -1; strobes = 0; rdata = 8'hxx; err = 1'bx;
    @(negedge clk);
    req_addr[idx*8 +: 8]  = addr;
    req_wdata[idx*8 +: 8] = wdata;
    req_valid[idx]        = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == drop_at) req_valid[idx] = 1'b0;
      if (regmap_in) strobes++;
      if (req_done[idx]) begin
        lat = c; rdata = rsp_rdata; err = req_err;
        break;
      end
    end
    req_valid[idx] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (req_done !== 2'b00) $display("FAIL reset req_done: got %b want 00", req_done); else passed++;
    total++; if (req_err !== 1'b0) $display("FAIL reset req_err: got %b want 0", req_err); else passed++;
    total++; if (rsp_rdata !== 8'h00) $display("FAIL reset rsp_rdata: got %h want 00", rsp_rdata); else passed++;
    total++; if (regmap_in !== 1'b0) $display("FAIL reset regmap_in: got %b want 0", regmap_in); else passed++;
    total++; if (regmap_out !== 1'b0) $display("FAIL reset regmap_out: got %b want 0", regmap_out); else passed++;
    total++; if (addr_bus !== 8'h00) $display("FAIL reset addr_bus: got %h want 00", addr_bus); else passed++;
    total++; if (data_bus !== 8'hFF) $display("FAIL reset data_bus released: got %h want FF(pulled)", data_bus); else passed++;
  endtask

  task automatic test_single_read();
    int lat, strobes; logic [7:0] rd; logic err;
    do_access(0, 8'h01, 8'h00, 0, lat, strobes, rd, err);
    total++; if (lat !== 4) $display("FAIL read latency: got %0d want 4", lat); else passed++;
    total++; if (strobes !== 1) $display("FAIL read strobe cycles: got %0d want 1", strobes); else passed++;
    total++; if (rd !== 8'hF3) $display("FAIL read rdata: got %h want F3", rd); else passed++;
    total++; if (err !== 1'b0) $display("FAIL read err: got %b want 0", err); else passed++;
  endtask

  task automatic test_write_read();
    int lat, strobes; logic [7:0] rd; logic err;
    do_access(1, 8'h85, 8'h5A, 0, lat, strobes, rd, err);
    total++; if (lat !== 4) $display("FAIL write latency: got %0d want 4", lat); else passed++;
    total++; if (rd !== 8'h00 || err !== 1'b0) $display("FAIL write rsp: got %h/%b want 00/0", rd, err); else passed++;
    do_access(1, 8'h05, 8'h00, 0, lat, strobes, rd, err);
    total++; if (rd !== 8'h5A || err !== 1'b0) $display("FAIL readback: got %h/%b want 5A/0", rd, err); else passed++;
    total++; if (conflicts !== 0) $display("FAIL bus conflict cycles: got %0d want 0", conflicts); else passed++;
  endtask

  task automatic test_drop_after_grant();
    int lat, strobes; logic [7:0] rd; logic err;
    do_access(0, 8'h02, 8'h00, 1, lat, strobes, rd, err);
    total++; if (lat !== 4) $display("FAIL dropped-valid latency: got %0d want 4", lat); else passed++;
    total++; if (rd !== 8'h22) $display("FAIL dropped-valid rdata: got %h want 22", rd); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat, strobes; logic [7:0] rd; logic err;
    do_access(0, 8'h0A, 8'h00, 0, lat, strobes, rd, err);
    total++; if (rd !== 8'h00 || err !== 1'b0) $display("FAIL oor read: got %h/%b want 00/0", rd, err); else passed++;
    do_access(0, 8'h8A, 8'h77, 0, lat, strobes, rd, err);
    total++; if (lat !== 4 || err !== 1'b0) $display("FAIL oor write: got lat %0d err %b want 4/0", lat, err); else passed++;
    do_access(0, 8'h02, 8'h00, 0, lat, strobes, rd, err);
    total++; if (rd !== 8'h22) $display("FAIL oor write aliased reg2: got %h want 22", rd); else passed++;
  endtask

  task automatic test_contention();
    int ev_idx [4];
    int ev_cyc [4];
    logic [7:0] ev_rd [4];
    int n = 0;
    int exp_idx [4] = '{0, 1, 0, 1};
    int exp_cyc [4] = '{4, 9, 14, 19};
    apply_reset();
    @(negedge clk);
    req_addr  = {8'h02, 8'h01};
    req_wdata = '0;
    req_valid = 2'b11;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        ev_idx[n] = req_done[1] ? 1 : 0;
        ev_cyc[n] = c;
        ev_rd[n]  = rsp_rdata;
        n++;
      end
    end
    req_valid = 2'b00;
    total++; if (n !== 4) $display("FAIL contention done count: got %0d want 4", n); else passed++;
    for (int i = 0; i < n; i++) begin
      total++;
      if (ev_idx[i] !== exp_idx[i] || ev_cyc[i] !== exp_cyc[i] ||
          ev_rd[i] !== (exp_idx[i] == 0 ? 8'hF3 : 8'h22))
        $display("FAIL contention done %0d: got req %0d cyc %0d rd %h want req %0d cyc %0d",
                 i, ev_idx[i], ev_cyc[i], ev_rd[i], exp_idx[i], exp_cyc[i]);
      else passed++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, strobes; logic [7:0] rd; logic err;
    ack_en = 1'b0;
    do_access(1, 8'h03, 8'h00, 0, lat, strobes, rd, err);
    ack_en = 1'b1;
    total++; if (lat !== TIMEOUT + 3) $display("FAIL timeout latency: got %0d want %0d", lat, TIMEOUT + 3); else passed++;
    total++; if (err !== 1'b1 || rd !== 8'h00) $display("FAIL timeout rsp: got %h/%b want 00/1", rd, err); else passed++;
    do_access(1, 8'h01, 8'h00, 0, lat, strobes, rd, err);
    total++; if (lat !== 4 || rd !== 8'hF3 || err !== 1'b0)
      $display("FAIL after-timeout access: got lat %0d %h/%b want 4 F3/0", lat, rd, err); else passed++;
  endtask

  task automatic test_reset_in_wait();
    int lat, strobes, dones; logic [7:0] rd; logic err;
    @(negedge clk);
    req_addr[7:0] = 8'h01;
    req_valid[0]  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (regmap_out !== 1'b1) $display("FAIL pre-reset WAIT regmap_out: got %b want 1", regmap_out); else passed++;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    total++; if (regmap_out !== 1'b0 || regmap_in !== 1'b0 || req_done !== 2'b00)
      $display("FAIL reset-in-wait ctrl: got out %b in %b done %b want 0 0 00", regmap_out, regmap_in, req_done); else passed++;
    total++; if (data_bus !== 8'hFF || addr_bus !== 8'h00)
      $display("FAIL reset-in-wait bus: got data %h addr %h want FF 00", data_bus, addr_bus); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_done != 2'b00) dones++;
    end
    total++; if (dones !== 0) $display("FAIL lost access pulsed done: got %0d want 0", dones); else passed++;
    do_access(0, 8'h01, 8'h00, 0, lat, strobes, rd, err);
    total++; if (lat !== 4 || rd !== 8'hF3 || err !== 1'b0)
      $display("FAIL reissued access: got lat %0d %h/%b want 4 F3/0", lat, rd, err); else passed++;
  endtask

  initial begin
    mem = '{8'h00, 8'hF3, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    regmap_data_available = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_drop_after_grant();
    test_out_of_range();
    test_contention();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regmap_arbiter.md
# regmap_arbiter

Controller that sequences all accesses to the register map block and shares its single address/data bus among NUM_REQ requesters (SPI front end, UART front end, internal housekeeping). It grants one requester at a time (round-robin), runs the register map's strobe/acknowledge handshake, returns read data, and flags accesses that never complete. It sits between the host-interface front ends and the register map, and is the only block that drives the register map's control inputs.

## Interface
- NUM_REQ, 2: number of requesters (2..4).
- TIMEOUT, 15: WAIT-state cycles allowed before an access is aborted with error.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester access request, held until its req_done.
- req_addr  in  8*NUM_REQ  per-requester address; bit 7 = 1 write, 0 read; bits 6:0 register index.
- req_wdata  in  8*NUM_REQ  per-requester write data.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  1  valid with req_done; 1 = timeout.
- rsp_rdata  out  8  read data, valid with req_done (0x00 on write or error).
- regmap_in  out  1  access strobe to register map.
- regmap_out  out  1  register map drive enable for data_bus.
- regmap_data_available  in  1  register map completion pulse.
- addr_bus  out  8  address to register map.
- data_bus  inout  8  shared data bus; driven by the arbiter only in ISSUE.

## Operation
- States: IDLE, ISSUE, TURN, WAIT, DONE.
- IDLE: if any req_valid, pick a winner by round-robin (first requester with req_valid set, searching upward from last_grant+1, wrapping); latch index, addr, wdata; → ISSUE. last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- ISSUE (1 cycle): regmap_in=1, addr_bus=latched addr, data_bus driven with latched wdata; → TURN.
- TURN (1 cycle): regmap_in=0, data_bus released; regmap_out=0; → WAIT.
- WAIT: regmap_out=1 for reads only; timeout counter increments each cycle. On regmap_data_available=1: capture data_bus into rsp_rdata (reads) or 0x00 (writes), err=0, → DONE. If counter reaches TIMEOUT first: rsp_rdata=0x00, err=1, → DONE. data_available wins if it coincides with the timeout.
- DONE (1 cycle): req_done[grant]=1, req_err valid; update last_grant; counter cleared; → IDLE.
- Out-of-range index (bits 6:0 ≥ 8): passed through unchanged; the register map ignores the write / returns 0x00 and still acknowledges, so err=0.
- Requester dropping req_valid after grant: access completes; done still pulses.
- regmap_data_available outside WAIT: ignored.
- Reset (any state): immediately to IDLE, all outputs to reset values, data_bus released; the in-flight access is lost and the requester must reissue.

## Timing
- Reset values: req_done=0, req_err=0, rsp_rdata=0x00, regmap_in=0, regmap_out=0, addr_bus=0x00, data_bus high-Z, last_grant=NUM_REQ-1.
- All outputs are registered.
- Nominal access: request sampled at edge E0; ISSUE E0–E1; TURN E1–E2; WAIT E2–E3, where data_available is sampled high at E3; DONE E3–E4 with req_done high.
- Grant to done is 4 cycles. Back-to-back accesses are 5 cycles apart, which guarantees the register map is back in IDLE before the next strobe.
- data_bus is never driven by both sides: the arbiter drives in ISSUE only, regmap_out is high in WAIT only, and TURN separates them.
- Worst case: done at TIMEOUT+3 cycles after grant.

## Structure
- Shared package/include regmap_defs: state encoding, RW_BIT=7, REGMAP_MAXADDR=8, default TIMEOUT.
- Sub-module rr_arbiter holds the combinational round-robin grant from req_valid and last_grant, plus the pointer register. It is reused by other shared-resource controllers.
- Timeout counter width: $clog2(TIMEOUT+1).

## Test plan
- Single read: req 0, addr 0x01 -> regmap_in pulses 1 cycle, req_done[0] 4 cycles after grant, rsp_rdata=0xF3, req_err=0.
- Write then read: req 1 writes 0x85/0x5A, then reads 0x05 -> second done returns 0x5A; no cycle has both arbiter drive and regmap_out.
- Contention: req 0 and req 1 held continuously -> grants alternate 0,1,0,1 with done pulses 5 cycles apart; after reset, 0 is granted first.
- Out of range: read 0x0A -> rsp_rdata=0x00, err=0; write 0x8A -> no register changes.
- Timeout: regmap model never acknowledges -> req_done with req_err=1, rsp_rdata=0x00, at TIMEOUT+3 cycles; next request is served normally.
- Reset in WAIT: rst_n low for 1 cycle -> outputs at reset values, data_bus high-Z, no req_done; reissued request completes.
